// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: |a|*|b| over WIDTH RUN cycles, with the product sign alongside.
// Optional EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod_mag,
  output logic               sign_x
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q;
  logic [PW-1:0]   mcand_q, acc_q, prod_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            sgn_q, sign_q, busy_q, done_q;

  logic [WIDTH-1:0] mag_a_d, mag_b_d, mplier_d;
  logic [PW-1:0]    acc_d;
  logic             sgn_d, last_d;

  always_comb begin
    // The most-negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    mag_a_d  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    mag_b_d  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    sgn_d    = (a[WIDTH-1] ^ b[WIDTH-1]) & (|a) & (|b);
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_d = mplier_q >> 1;
`ifdef EARLY_TERM_EN
    last_d   = (cnt_q == CW'(WIDTH - 1)) || (mplier_d == '0);
`else
    last_d   = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= sgn_d;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            prod_q  <= acc_d;
            sign_q  <= sgn_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign prod_mag = prod_q;
  assign sign_x   = sign_q;

endmodule
